taylor_cos_scheduler: RTL and testbench

//  Shares one TaylorSeries16 cosine core among NREQ requesters.
//  - Round-robin arbitration over the requesters.
//  - Drives the core's start/ready handshake and holds the angle stable.
//  - Returns each result tagged with the requester id on one response channel with backpressure.
//  - Sits between the angle producers (sweep/DDS/test logic) and the single cosine datapath.

---
 rtl/taylor_cos_scheduler_pkg.sv | 21 ++
 rtl/taylor_cos_scheduler_if.sv | 36 +++
 rtl/taylor_cos_scheduler_arbiter.sv | 38 +++
 rtl/taylor_cos_scheduler.sv | 153 +++++++++++++++
 tb/tb_taylor_cos_scheduler.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/taylor_cos_scheduler_pkg.sv
// Shared constants, FSM state type and angle clamp helper for the Taylor cosine scheduler.
// Angles and results are unsigned fixed point [2:16], so 65536 represents 1.0.
package taylor_cos_pkg;

    localparam int W         = 18;
    localparam int FRAC_BITS = 16;
    // 1.0 + 0.5708 in [2:16]: the largest angle (~pi/2) the core is specified for.
    localparam int ANGLE_MAX = (1 << FRAC_BITS) + 37408;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } cos_state_t;

    function automatic logic [31:0] clamp_angle(input logic [31:0] angle, input logic [31:0] limit);
        return (angle > limit) ? limit : angle;
    endfunction

endpackage

// File: rtl/taylor_cos_scheduler_if.sv
// Request, response and cosine-core signal bundle for taylor_cos_scheduler.
// The master modport is the scheduler's view; slave is the requesters/consumer/core side.
interface taylor_cos_scheduler_if #(
    parameter int NREQ = 4,
    parameter int W    = 18
);

    logic [NREQ-1:0]         req_valid;
    logic [NREQ*W-1:0]       req_angle;
    logic [NREQ-1:0]         req_ready;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [$clog2(NREQ)-1:0] rsp_id;
    logic [W-1:0]            rsp_data;
    logic                    rsp_clamp;
    logic                    rsp_err;

    logic                    core_start;
    logic [W-1:0]            core_angle;
    logic                    core_ready;
    logic [W-1:0]            core_cos;

    modport master (
        input  req_valid, req_angle, rsp_ready, core_ready, core_cos,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_clamp, rsp_err,
               core_start, core_angle
    );

    modport slave (
        output req_valid, req_angle, rsp_ready, core_ready, core_cos,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_clamp, rsp_err,
               core_start, core_angle
    );

endinterface

// File: rtl/taylor_cos_scheduler_arbiter.sv
// Purely combinational round-robin arbiter: grants the first valid requester at or after ptr.
// The owning FSM advances ptr; this block only looks.
module taylor_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         valid,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    logic [IW:0] slot;

    // Scan from the farthest offset back to ptr so the nearest valid slot is the last writer.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        slot  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            slot = {1'b0, ptr} + (IW+1)'(k);
            if (slot >= (IW+1)'(NREQ)) begin
                slot = slot - (IW+1)'(NREQ);
            end
            if (valid[slot[IW-1:0]]) begin
                idx = slot[IW-1:0];
                any = 1'b1;
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/taylor_cos_scheduler.sv
// Round-robin scheduler sharing one TaylorSeries16 cosine core among NREQ angle requesters.
// Define COS_SCHED_TIMEOUT_EN to bound the WAIT state and report core timeouts on rsp_err.
module taylor_cos_scheduler
    import taylor_cos_pkg::cos_state_t;
    import taylor_cos_pkg::IDLE;
    import taylor_cos_pkg::ISSUE;
    import taylor_cos_pkg::WAIT;
    import taylor_cos_pkg::RESP;
    import taylor_cos_pkg::clamp_angle;
#(
    parameter int NREQ      = 4,
    parameter int W         = taylor_cos_pkg::W,
    parameter int START_LEN = 2,
    parameter int ANGLE_MAX = taylor_cos_pkg::ANGLE_MAX,
    parameter int TIMEOUT   = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    taylor_cos_scheduler_if.master bus,
    output logic                   busy
);

    localparam int IW = $clog2(NREQ);
    localparam int SW = $clog2(START_LEN + 1);
    localparam logic [W-1:0] ANGLE_LIM = W'(ANGLE_MAX);

    cos_state_t      state;
    cos_state_t      state_next;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   id_q;
    logic [NREQ-1:0] grant;
    logic            grant_any;
    logic [W-1:0]    sel_angle;
    logic [W-1:0]    angle_q;
    logic [W-1:0]    data_q;
    logic            sel_clamp;
    logic            clamp_q;
    logic            core_ready_q;
    logic [SW-1:0]   start_cnt;
    logic            accept;
    logic            issue_done;
    logic            complete;
    logic            timed_out;
    logic            err_q;

    taylor_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arbiter (
        .valid (bus.req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    always_comb begin
        sel_angle = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_angle = bus.req_angle[i*W +: W];
            end
        end
    end

    // Holding reset low must suppress the accept pulse even though the FSM already sits in IDLE.
    assign accept     = reset && (state == IDLE) && grant_any;
    assign sel_clamp  = (sel_angle > ANGLE_LIM);
    assign issue_done = (state == ISSUE) && (start_cnt == SW'(START_LEN - 1));
    assign complete   = (state == WAIT) && bus.core_ready && !core_ready_q;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)                 state_next = ISSUE;
            ISSUE:   if (issue_done)             state_next = WAIT;
            WAIT:    if (complete || timed_out)  state_next = RESP;
            RESP:    if (bus.rsp_ready)          state_next = IDLE;
            default:                             state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The angle register doubles as core_angle, so it stays put from ISSUE until the response leaves.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr          <= '0;
            id_q         <= '0;
            angle_q      <= '0;
            clamp_q      <= 1'b0;
            data_q       <= '0;
            core_ready_q <= 1'b0;
            start_cnt    <= '0;
        end else begin
            core_ready_q <= bus.core_ready;
            start_cnt    <= (state == ISSUE) ? start_cnt + 1'b1 : '0;
            if (accept) begin
                id_q    <= grant_idx;
                clamp_q <= sel_clamp;
                angle_q <= W'(clamp_angle(32'(sel_angle), 32'(ANGLE_LIM)));
                ptr     <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (complete) begin
                data_q <= bus.core_cos;
            end else if (timed_out) begin
                data_q <= '0;
            end
        end
    end

`ifdef COS_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;

    assign timed_out = (state == WAIT) && !complete && (wait_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (accept) begin
                err_q <= 1'b0;
            end else if (timed_out) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timed_out = 1'b0;
    assign err_q     = 1'b0;
`endif

    assign bus.req_ready  = accept ? grant : '0;
    assign bus.core_start = (state == ISSUE);
    assign bus.core_angle = angle_q;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_clamp  = clamp_q;
    assign bus.rsp_err    = err_q;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_taylor_cos_scheduler.sv
// Self-checking bench for taylor_cos_scheduler: behavioural cosine core plus a round-robin reference model.
// Define COS_SCHED_TIMEOUT_EN for both bench and RTL to exercise the core-timeout path.
module tb_taylor_cos_scheduler;

    localparam int NREQ       = 4;
    localparam int W          = 18;
    localparam int ANGLE_MAX  = 102944;
    localparam int CORE_DELAY = 10;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    bit          pend       [NREQ];
    int unsigned pend_angle [NREQ];
    int          rr_ptr      = 0;
    bit          core_enable = 1'b1;

    logic         prev_start = 1'b0;
    int           countdown  = 0;
    logic [W-1:0] cap_angle  = '0;

    taylor_cos_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();

    taylor_cos_scheduler #(
        .NREQ      (NREQ),
        .W         (W),
        .START_LEN (2),
        .ANGLE_MAX (ANGLE_MAX),
        .TIMEOUT   (64)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    // Two-term Taylor cosine, saturated at zero; the exact curve only needs to be deterministic.
    function automatic logic [W-1:0] cos_model(input int unsigned a);
        longint v;
        v = 65536 - (longint'(a) * longint'(a)) / 131072;
        if (v < 0) v = 0;
        return W'(v);
    endfunction

    // Core model: ready rises CORE_DELAY cycles after start falls and stays high until the next start.
    always @(posedge clock) begin
        if (!reset) begin
            bus.core_ready <= 1'b0;
            bus.core_cos   <= '0;
            prev_start     <= 1'b0;
            countdown      <= 0;
        end else begin
            prev_start <= bus.core_start;
            if (bus.core_start) begin
                bus.core_ready <= 1'b0;
                countdown      <= 0;
                cap_angle      <= bus.core_angle;
            end else if (prev_start && core_enable) begin
                countdown <= CORE_DELAY;
            end else if (countdown > 1) begin
                countdown <= countdown - 1;
            end else if (countdown == 1) begin
                countdown      <= 0;
                bus.core_ready <= 1'b1;
                bus.core_cos   <= cos_model(cap_angle);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input int unsigned angle);
        pend[idx]       = 1'b1;
        pend_angle[idx] = angle;
        bus.req_valid[idx]          = 1'b1;
        bus.req_angle[idx*W +: W]   = W'(angle);
        #1;
    endtask

    function automatic int nextGrant();
        for (int k = 0; k < NREQ; k++) begin
            if (pend[(rr_ptr + k) % NREQ]) return (rr_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int unsigned randAngle();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, (1 << W) - 1);
            1:       return ANGLE_MAX;
            2:       return ANGLE_MAX + 1;
            default: return $urandom_range(0, ANGLE_MAX);
        endcase
    endfunction

    task automatic waitGrant(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.req_ready != '0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("grant_seen", 32'(seen), 32'd1);
    endtask

    task automatic doReset();
        reset         = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        rr_ptr = 0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic serveNext(input int hold);
        int           g;
        int unsigned  exp_angle;
        logic [W-1:0] exp_data;
        bit           exp_clamp;
        bit           exp_err;
        bit           seen;
        g         = nextGrant();
        exp_clamp = (pend_angle[g] > ANGLE_MAX);
        exp_angle = exp_clamp ? ANGLE_MAX : pend_angle[g];
        exp_data  = cos_model(exp_angle);
        exp_err   = 1'b0;
`ifdef COS_SCHED_TIMEOUT_EN
        if (!core_enable) begin
            exp_data = '0;
            exp_err  = 1'b1;
        end
`endif
        waitGrant(seen);
        checkOutput("req_ready_onehot", 32'(bus.req_ready), 32'(1) << g);
        checkOutput("busy_before_accept", 32'(busy), 32'd0);
        tick();
        pend[g]          = 1'b0;
        bus.req_valid[g] = 1'b0;
        rr_ptr           = (g + 1) % NREQ;
        checkOutput("core_start_cycle1", 32'(bus.core_start), 32'd1);
        checkOutput("core_angle", 32'(bus.core_angle), exp_angle);
        checkOutput("req_ready_after_accept", 32'(bus.req_ready), 32'd0);
        tick();
        checkOutput("core_start_cycle2", 32'(bus.core_start), 32'd1);
        tick();
        checkOutput("core_start_done", 32'(bus.core_start), 32'd0);
        checkOutput("core_angle_hold", 32'(bus.core_angle), exp_angle);
        seen = 1'b0;
        for (int c = 0; c < 120; c++) begin
            if (bus.rsp_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("rsp_seen", 32'(seen), 32'd1);
        checkOutput("rsp_id", 32'(bus.rsp_id), 32'(g));
        checkOutput("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
        checkOutput("rsp_clamp", 32'(bus.rsp_clamp), 32'(exp_clamp));
        checkOutput("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        for (int c = 0; c < hold; c++) begin
            tick();
            checkOutput("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("bp_rsp_data", 32'(bus.rsp_data), 32'(exp_data));
            checkOutput("bp_rsp_id", 32'(bus.rsp_id), 32'(g));
            checkOutput("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        checkOutput("no_grant_on_fire", 32'(bus.req_ready), 32'd0);
        tick();
        bus.rsp_ready = 1'b0;
        checkOutput("rsp_valid_cleared", 32'(bus.rsp_valid), 32'd0);
        checkOutput("idle_after_fire", 32'(busy), 32'd0);
    endtask

    initial begin
        bit seen;
        bus.req_valid = '0;
        bus.req_angle = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        reset = 1'b0;
        #12;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_core_start", 32'(bus.core_start), 32'd0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_core_angle", 32'(bus.core_angle), 32'd0);
        checkOutput("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
        reset = 1'b1;
        tick();

        $display("[TB] single request");
        applyStimulus(0, 64);
        serveNext(0);

        $display("[TB] round-robin order");
        doReset();
        for (int i = 0; i < NREQ; i++) applyStimulus(i, $urandom_range(0, ANGLE_MAX));
        repeat (NREQ) serveNext(0);
        applyStimulus(0, $urandom_range(0, ANGLE_MAX));
        applyStimulus(3, $urandom_range(0, ANGLE_MAX));
        serveNext(0);
        serveNext(0);

        $display("[TB] backpressure");
        applyStimulus(1, 30000);
        applyStimulus(2, 45000);
        serveNext(5);
        serveNext(0);

        $display("[TB] clamp boundaries");
        applyStimulus(1, 32'h1FFFF);
        serveNext(1);
        applyStimulus(2, ANGLE_MAX);
        serveNext(0);
        applyStimulus(3, ANGLE_MAX + 1);
        serveNext(0);

        $display("[TB] reset during WAIT");
        applyStimulus(3, 5000);
        waitGrant(seen);
        checkOutput("rw_grant", 32'(bus.req_ready), 32'd8);
        tick();
        pend[3]          = 1'b0;
        bus.req_valid[3] = 1'b0;
        repeat (4) tick();
        checkOutput("rw_in_wait", 32'(busy && !bus.core_start), 32'd1);
        applyStimulus(2, 20000);
        reset = 1'b0;
        #1;
        rr_ptr = 0;
        checkOutput("rw_busy", 32'(busy), 32'd0);
        checkOutput("rw_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rw_core_start", 32'(bus.core_start), 32'd0);
        checkOutput("rw_core_angle", 32'(bus.core_angle), 32'd0);
        checkOutput("rw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (3) tick();
        checkOutput("rw_no_rsp", 32'(bus.rsp_valid), 32'd0);
        reset = 1'b1;
        #1;
        serveNext(0);

`ifdef COS_SCHED_TIMEOUT_EN
        $display("[TB] core timeout");
        core_enable = 1'b0;
        applyStimulus(1, 1000);
        serveNext(0);
        core_enable = 1'b1;
        applyStimulus(0, 2000);
        serveNext(0);
`endif

        $display("[TB] randomized traffic");
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) applyStimulus(i, randAngle());
            end
            if (nextGrant() < 0) applyStimulus(int'($urandom_range(0, NREQ - 1)), randAngle());
            serveNext(int'($urandom_range(0, 3)));
        end
        for (int d = 0; d < NREQ; d++) begin
            if (nextGrant() >= 0) serveNext(0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
